// File: rtl/vga_mem_arbiter.sv
// Video RAM arbiter: the VGA controller has fixed priority, CPU accesses are slotted
// into cycles the VGA announced as free one cycle ahead.
module vga_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int WAIT_W = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [ADDR_W-1:0] i_vga_addr,
    input  logic              i_vga_cs,
    input  logic              i_vga_access,
    output logic [DATA_W-1:0] o_vga_dat,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_dat,
    input  logic              i_cpu_cs,
    input  logic              i_cpu_we,
    output logic [DATA_W-1:0] o_cpu_dat,
    output logic              o_cpu_ack,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_dat,
    input  logic [DATA_W-1:0] i_ram_dat,
    output logic              o_ram_cs,
    output logic              o_ram_we,
    input  logic              i_clr_status,
    output logic              o_collision,
    output logic [WAIT_W-1:0] o_max_wait
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_XFER,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_dat;
    logic              r_we;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [DATA_W-1:0] r_cpu_dat;
    logic              r_ack;
    logic              r_collision;
    logic [WAIT_W-1:0] r_max_wait;
    logic              w_cpu_owns;

    // A VGA strobe during XFER is a protocol violation; VGA still wins the RAM.
    assign w_cpu_owns = (r_state == S_XFER) && !i_vga_cs;

    assign o_ram_addr  = w_cpu_owns ? r_addr : i_vga_addr;
    assign o_ram_cs    = w_cpu_owns | i_vga_cs;
    assign o_ram_we    = w_cpu_owns & r_we;
    assign o_ram_dat   = r_dat;
    assign o_vga_dat   = i_ram_dat;
    assign o_cpu_dat   = r_cpu_dat;
    assign o_cpu_ack   = r_ack;
    assign o_collision = r_collision;
    assign o_max_wait  = r_max_wait;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_dat       <= '0;
            r_we        <= 1'b0;
            r_wait_cnt  <= '0;
            r_cpu_dat   <= '0;
            r_ack       <= 1'b0;
            r_collision <= 1'b0;
            r_max_wait  <= '0;
        end else begin
            r_ack <= 1'b0;
            // Status clear sits first so a same-cycle set/update below overrides it.
            if (i_clr_status) begin
                r_collision <= 1'b0;
                r_max_wait  <= '0;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_cpu_cs) begin
                        r_addr     <= i_cpu_addr;
                        r_dat      <= i_cpu_dat;
                        r_we       <= i_cpu_we;
                        r_wait_cnt <= '0;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!i_vga_access) begin
                        r_state <= S_XFER;
                    end else if (r_wait_cnt != {WAIT_W{1'b1}}) begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_XFER: begin
                    if (i_vga_cs) begin
                        r_collision <= 1'b1;
                        r_state     <= S_WAIT;
                    end else begin
                        if (!r_we) begin
                            r_cpu_dat <= i_ram_dat;
                        end
                        r_max_wait <= (r_wait_cnt > r_max_wait) ? r_wait_cnt : r_max_wait;
                        r_ack      <= 1'b1;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Bench for vga_mem_arbiter: directed vector table, multi-cycle corner sequences
// and a random CPU/VGA traffic phase checked against a reference memory.
module tb_vga_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] vga_addr;
    logic        vga_cs, vga_access;
    logic [7:0]  vga_dat;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdat, cpu_rdat;
    logic        cpu_cs, cpu_we, cpu_ack;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdat, ram_rdat;
    logic        ram_cs, ram_we;
    logic        clr;
    logic        collision;
    logic [7:0]  max_wait;

    logic        bd_en;
    logic [15:0] bd_addr;
    logic [7:0]  bd_dat;

    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  dat;
        logic [7:0]  exp;
    } sb_t;
    sb_t q[$];

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  dat;
        int          nbusy;
        int          exp_lat;
        logic [7:0]  exp_rd;
        int          exp_nwe;
        logic [7:0]  exp_maxw;
    } vec_t;
    vec_t vecs[6];

    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] last_rd = 8'h00;

    always #5 clk = ~clk;

    vga_mem_arbiter #(.ADDR_W(16), .DATA_W(8), .WAIT_W(8)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_vga_addr(vga_addr), .i_vga_cs(vga_cs), .i_vga_access(vga_access), .o_vga_dat(vga_dat),
        .i_cpu_addr(cpu_addr), .i_cpu_dat(cpu_wdat), .i_cpu_cs(cpu_cs), .i_cpu_we(cpu_we),
        .o_cpu_dat(cpu_rdat), .o_cpu_ack(cpu_ack),
        .o_ram_addr(ram_addr), .o_ram_dat(ram_wdat), .i_ram_dat(ram_rdat),
        .o_ram_cs(ram_cs), .o_ram_we(ram_we),
        .i_clr_status(clr), .o_collision(collision), .o_max_wait(max_wait)
    );

    // 64K x 8 RAM: combinational read, synchronous write, plus a preload port.
    assign ram_rdat = mem[ram_addr];
    always @(posedge clk) begin
        if (bd_en) mem[bd_addr] <= bd_dat;
        else if (ram_cs && ram_we) mem[ram_addr] <= ram_wdat;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        bd_en = 1'b1; bd_addr = a; bd_dat = d;
        ref_mem[a] = d;
        @(negedge clk);
        bd_en = 1'b0;
    endtask

    task automatic pop_ack();
        sb_t e;
        if (q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL sb_empty: ack with no pending request at %0t", $time);
        end else begin
            e = q.pop_front();
            chk("cpu_dat", {24'h0, cpu_rdat}, {24'h0, e.exp});
            if (e.we) ref_mem[e.addr] = e.dat;
            else last_rd = e.exp;
        end
    endtask

    // One CPU transaction; VGA announces access in the first nbusy WAIT cycles.
    task automatic do_op(input logic we, input logic [15:0] addr, input logic [7:0] dat,
                         input logic [7:0] exp, input int nbusy, output int lat,
                         output int nwe, output logic [15:0] wa, output logic [7:0] wd);
        logic acc;
        sb_t  e;
        lat = -1; nwe = 0; wa = '0; wd = '0; acc = 1'b0;
        @(negedge clk);
        cpu_cs = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdat = dat;
        vga_cs = 1'b0; vga_access = 1'b0; vga_addr = 16'h1234;
        e.we = we; e.addr = addr; e.dat = dat; e.exp = exp;
        q.push_back(e);
        for (int c = 1; c <= 60 && lat < 0; c++) begin
            @(negedge clk);
            if (cpu_ack) begin
                lat = c; cpu_cs = 1'b0;
                pop_ack();
            end
            vga_cs = acc; acc = (c <= nbusy); vga_access = acc;
            #1;
            if (ram_cs && ram_we) begin nwe++; wa = ram_addr; wd = ram_wdat; end
            if (vga_cs) chk("vga_excl", {15'h0, ram_we, ram_addr}, {16'h0, vga_addr});
        end
        vga_cs = 1'b0; vga_access = 1'b0;
        if (lat < 0) begin
            n_chk++; n_err++; cpu_cs = 1'b0;
            $display("FAIL op_timeout: no ack for addr %0h within 60 cycles", addr);
        end
    endtask

    initial begin
        int lat, nwe, cnt;
        logic [15:0] wa;
        logic [7:0]  wd;
        sb_t e;
        int issued, wt, gap;
        logic busy, acc;

        vecs[0] = '{1'b0, 16'h1234, 8'h00, 0, 3, 8'h5A, 0, 8'd0};
        vecs[1] = '{1'b1, 16'h2000, 8'hA5, 0, 3, 8'h5A, 1, 8'd0};
        vecs[2] = '{1'b0, 16'h2000, 8'h00, 0, 3, 8'hA5, 0, 8'd0};
        vecs[3] = '{1'b0, 16'h1234, 8'h00, 4, 7, 8'h5A, 0, 8'd4};
        vecs[4] = '{1'b1, 16'h0042, 8'h3C, 2, 5, 8'h5A, 1, 8'd4};
        vecs[5] = '{1'b0, 16'h0042, 8'h00, 1, 4, 8'h3C, 0, 8'd4};

        rst = 1'b1; clr = 1'b0; bd_en = 1'b0; bd_addr = '0; bd_dat = '0;
        vga_addr = '0; vga_cs = 1'b0; vga_access = 1'b0;
        cpu_addr = '0; cpu_wdat = '0; cpu_cs = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
        preload(16'h1234, 8'h5A); preload(16'h2000, 8'h00); preload(16'h0042, 8'h00);
        preload(16'h3000, 8'h11); preload(16'h3100, 8'h00); preload(16'h5555, 8'hC3);
        for (int i = 0; i < 64; i++) preload(16'h4000 + 16'(i), 8'(i * 7 + 3));

        chk("rst_ack", {31'h0, cpu_ack}, 0);
        chk("rst_cpu_dat", {24'h0, cpu_rdat}, 0);
        chk("rst_collision", {31'h0, collision}, 0);
        chk("rst_max_wait", {24'h0, max_wait}, 0);
        chk("rst_ram_cs", {31'h0, ram_cs}, 0);
        chk("rst_ram_we", {31'h0, ram_we}, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            do_op(vecs[i].we, vecs[i].addr, vecs[i].dat, vecs[i].exp_rd, vecs[i].nbusy,
                  lat, nwe, wa, wd);
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
            chk($sformatf("vec%0d_nwe", i), nwe, vecs[i].exp_nwe);
            if (vecs[i].exp_nwe == 1)
                chk($sformatf("vec%0d_wr", i), {8'h0, wa, wd}, {8'h0, vecs[i].addr, vecs[i].dat});
            chk($sformatf("vec%0d_maxw", i), {24'h0, max_wait}, {24'h0, vecs[i].exp_maxw});
            chk($sformatf("vec%0d_coll", i), {31'h0, collision}, 0);
        end

        // Protocol violation: VGA strobes in the XFER cycle without announcing it.
        @(negedge clk);
        cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h3100; cpu_wdat = 8'h77;
        e.we = 1'b1; e.addr = 16'h3100; e.dat = 8'h77; e.exp = last_rd;
        q.push_back(e);
        @(negedge clk);
        vga_cs = 1'b0; vga_access = 1'b0;
        @(negedge clk);
        vga_cs = 1'b1; vga_addr = 16'h5555;
        #1;
        chk("viol_ram", {14'h0, ram_cs, ram_we, ram_addr}, {14'h0, 2'b10, 16'h5555});
        chk("viol_vga_dat", {24'h0, vga_dat}, 32'hC3);
        @(negedge clk);
        vga_cs = 1'b0;
        #1;
        chk("viol_coll", {31'h0, collision}, 1);
        chk("viol_no_ack", {31'h0, cpu_ack}, 0);
        lat = -1; nwe = 0;
        for (int c = 4; c <= 20 && lat < 0; c++) begin
            @(negedge clk);
            if (cpu_ack) begin lat = c; cpu_cs = 1'b0; pop_ack(); end
            #1;
            if (ram_cs && ram_we) begin nwe++; wa = ram_addr; wd = ram_wdat; end
        end
        chk("viol_lat", lat, 5);
        chk("viol_nwe", nwe, 1);
        chk("viol_wr", {8'h0, wa, wd}, {8'h0, 16'h3100, 8'h77});
        chk("viol_mem", {16'h0, mem[16'h3100], mem[16'h5555]}, {16'h0, 8'h77, 8'hC3});
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("clr_coll", {31'h0, collision}, 0);
        chk("clr_maxw", {24'h0, max_wait}, 0);

        // Reset while a write sits in WAIT.
        @(negedge clk);
        cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h3000; cpu_wdat = 8'hEE;
        @(negedge clk);
        vga_access = 1'b1;
        @(negedge clk);
        rst = 1'b1; cpu_cs = 1'b0; vga_cs = 1'b0;
        #1;
        chk("rstw_ram", {30'h0, ram_cs, ram_we}, 0);
        chk("rstw_ack", {31'h0, cpu_ack}, 0);
        chk("rstw_cpu_dat", {24'h0, cpu_rdat}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; vga_access = 1'b0;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            if (cpu_ack || (ram_cs && ram_we)) cnt++;
        end
        chk("rstw_quiet", cnt, 0);
        chk("rstw_mem", {24'h0, mem[16'h3000]}, 32'h11);
        do_op(1'b0, 16'h3000, 8'h00, 8'h11, 0, lat, nwe, wa, wd);
        chk("rstw_next_lat", lat, 3);

        // Random traffic against a VGA that announces 2 of every 8 cycles.
        busy = 1'b0; acc = 1'b0; issued = 0; wt = 0; gap = 0;
        for (int cyc = 0; cyc < 30000 && !(issued == 1000 && !busy); cyc++) begin
            @(negedge clk);
            if (cpu_ack) begin
                pop_ack();
                cpu_cs = 1'b0; busy = 1'b0; gap = $urandom_range(0, 2);
            end else if (busy) begin
                wt++;
                if (wt > 60) begin
                    n_chk++; n_err++;
                    $display("FAIL rnd_timeout: request %0d never acked", issued);
                    break;
                end
            end else if (gap > 0) begin
                gap--;
            end else if (issued < 1000) begin
                e.we = 1'($urandom_range(0, 1));
                e.addr = 16'h4000 + 16'($urandom_range(0, 63));
                e.dat = 8'($urandom);
                e.exp = e.we ? last_rd : ref_mem[e.addr];
                q.push_back(e);
                cpu_cs = 1'b1; cpu_we = e.we; cpu_addr = e.addr; cpu_wdat = e.dat;
                busy = 1'b1; wt = 0; issued++;
            end
            vga_cs = acc; acc = ((cyc % 8) < 2); vga_access = acc;
            vga_addr = 16'h4000 + 16'($urandom_range(0, 63));
            #1;
            if (vga_cs) begin
                chk("rnd_vga_dat", {24'h0, vga_dat}, {24'h0, ref_mem[vga_addr]});
                chk("rnd_vga_excl", {15'h0, ram_we, ram_addr}, {16'h0, vga_addr});
            end
        end
        vga_cs = 1'b0; vga_access = 1'b0;
        chk("rnd_issued", issued, 1000);
        chk("rnd_sb_empty", q.size(), 0);
        chk("rnd_coll", {31'h0, collision}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
